// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared definitions for the instruction-decode stage:
//   - default field widths (opcode and register address)
//   - ALU opcode encodings
//   - packed struct of the decoded fields, laid out exactly like the
//     instruction word {op, oper1, oper2, dest}, MSB to LSB
//   - decode() helper that reinterprets a default-width instruction word
// No ports (package).
// ---------------------------------------------------------------------------
package id_pkg;

  localparam int OP_LEN_DEF   = 2;
  localparam int ADDR_LEN_DEF = 5;
  localparam int INST_LEN_DEF = OP_LEN_DEF + 3 * ADDR_LEN_DEF;

  // ALU opcode encodings
  localparam logic [OP_LEN_DEF-1:0] ADD = 2'b00;
  localparam logic [OP_LEN_DEF-1:0] SUB = 2'b01;
  localparam logic [OP_LEN_DEF-1:0] AND = 2'b10;
  localparam logic [OP_LEN_DEF-1:0] OR  = 2'b11;

  // Member order matches the instruction bit order, so a plain cast decodes.
  typedef struct packed {
    logic [OP_LEN_DEF-1:0]   op;
    logic [ADDR_LEN_DEF-1:0] oper1;
    logic [ADDR_LEN_DEF-1:0] oper2;
    logic [ADDR_LEN_DEF-1:0] dest;
  } dec_t;

  function automatic dec_t decode(input logic [INST_LEN_DEF-1:0] inst);
    return dec_t'(inst);
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// ---------------------------------------------------------------------------
// id_scoreboard
// One pending bit per architectural register. A bit is set when an
// instruction writing that register is accepted and cleared when its
// writeback completes. Two combinational lookup ports report whether a
// source register still has a write in flight.
//
// Ports:
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset, clears every pending bit
//   set_en    in   mark set_idx pending (takes effect next cycle)
//   set_idx   in   register to mark
//   clr_en    in   clear clr_idx (takes effect next cycle)
//   clr_idx   in   register to clear
//   rd1_idx   in   lookup address 1
//   rd1_pend  out  register rd1_idx has a write in flight
//   rd2_idx   in   lookup address 2
//   rd2_pend  out  register rd2_idx has a write in flight
//
// When set and clear hit the same register in the same cycle the set wins:
// the newly accepted write is younger than the one retiring.
// With ZERO_REG=1 register 0 is hardwired non-pending.
// ---------------------------------------------------------------------------
module id_scoreboard
  import id_pkg::*;
#(
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                set_en,
  input  logic [ADDR_LEN-1:0] set_idx,
  input  logic                clr_en,
  input  logic [ADDR_LEN-1:0] clr_idx,
  input  logic [ADDR_LEN-1:0] rd1_idx,
  output logic                rd1_pend,
  input  logic [ADDR_LEN-1:0] rd2_idx,
  output logic                rd2_pend
);

  localparam int DEPTH = 2 ** ADDR_LEN;

  logic [DEPTH-1:0] pend_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;

      // Register 0 can never become pending when it is the zero register.
      assign set_hit = set_en && (set_idx == ADDR_LEN'(gi)) && !(ZERO_REG && (gi == 0));
      assign clr_hit = clr_en && (clr_idx == ADDR_LEN'(gi));

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          pend_reg[gi] <= 1'b0;
        end else if (set_hit) begin
          pend_reg[gi] <= 1'b1;
        end else if (clr_hit) begin
          pend_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Lookups read the registered bits only: a clear issued this cycle is not
  // visible until the next one.
  logic rd1_zero;
  logic rd2_zero;

  assign rd1_zero = ZERO_REG && (rd1_idx == '0);
  assign rd2_zero = ZERO_REG && (rd2_idx == '0);

  assign rd1_pend = pend_reg[rd1_idx] && !rd1_zero;
  assign rd2_pend = pend_reg[rd2_idx] && !rd2_zero;

endmodule

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Registered instruction-decode stage between fetch and the register-file
// read / ALU stage. Each accepted instruction is split into ALU opcode,
// two source addresses and a destination address, all registered. A
// destination scoreboard holds back any instruction that reads a register
// whose write has not yet been written back.
//
// Ports:
//   clk         in   clock, rising edge
//   rstn        in   asynchronous active-low reset
//   inst        in   {op, oper1, oper2, dest}, MSB to LSB
//   inst_valid  in   upstream holds a valid inst
//   inst_ready  out  stage accepts inst this cycle (combinational)
//   wb_valid    in   writeback of wb_dest completes this cycle
//   wb_dest     in   register being written back
//   out_valid   out  decoded fields are valid
//   out_ready   in   downstream consumes the output this cycle
//   alu_sig     out  registered opcode
//   oper1       out  registered source 1 address
//   oper2       out  registered source 2 address
//   dest        out  registered destination address
//   mem_read    out  one-cycle register-file read strobe per new instruction
//   stall_cnt   out  saturating count of hazard-stall cycles
//
// INST_LEN must equal OP_LEN + 3*ADDR_LEN.
// ---------------------------------------------------------------------------
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int OP_LEN   = OP_LEN_DEF,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int INST_LEN = OP_LEN_DEF + 3 * ADDR_LEN_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [INST_LEN-1:0] inst,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic                wb_valid,
  input  logic [ADDR_LEN-1:0] wb_dest,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_LEN-1:0]   alu_sig,
  output logic [ADDR_LEN-1:0] oper1,
  output logic [ADDR_LEN-1:0] oper2,
  output logic [ADDR_LEN-1:0] dest,
  output logic                mem_read,
  output logic [CNT_W-1:0]    stall_cnt
);

  // Field slicing of the incoming instruction.
  logic [OP_LEN-1:0]   f_op;
  logic [ADDR_LEN-1:0] f1;
  logic [ADDR_LEN-1:0] f2;
  logic [ADDR_LEN-1:0] fd;

  assign f_op = inst[INST_LEN-1 -: OP_LEN];
  assign f1   = inst[3*ADDR_LEN-1 -: ADDR_LEN];
  assign f2   = inst[2*ADDR_LEN-1 -: ADDR_LEN];
  assign fd   = inst[ADDR_LEN-1:0];

  // Output and counter state.
  logic                out_valid_reg;
  logic [OP_LEN-1:0]   alu_sig_reg;
  logic [ADDR_LEN-1:0] oper1_reg;
  logic [ADDR_LEN-1:0] oper2_reg;
  logic [ADDR_LEN-1:0] dest_reg;
  logic                mem_read_reg;
  logic [CNT_W-1:0]    stall_cnt_reg;

  logic pend1;
  logic pend2;
  logic hazard;
  logic acc;

  assign hazard = pend1 | pend2;

  // Ready depends only on registered state and the instruction fields, never
  // on inst_valid, so upstream may wait for ready before raising valid.
  assign inst_ready = (!out_valid_reg || out_ready) && !hazard;
  assign acc        = inst_valid && inst_ready;

  id_scoreboard #(
    .ADDR_LEN (ADDR_LEN),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .set_en   (acc),
    .set_idx  (fd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_dest),
    .rd1_idx  (f1),
    .rd1_pend (pend1),
    .rd2_idx  (f2),
    .rd2_pend (pend2)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_reg <= 1'b0;
      alu_sig_reg   <= '0;
      oper1_reg     <= '0;
      oper2_reg     <= '0;
      dest_reg      <= '0;
      mem_read_reg  <= 1'b0;
    end else begin
      // Strobe marks arrival of a new instruction only; a held output does
      // not re-strobe the register file.
      mem_read_reg <= acc;
      if (acc) begin
        out_valid_reg <= 1'b1;
        alu_sig_reg   <= f_op;
        oper1_reg     <= f1;
        oper2_reg     <= f2;
        dest_reg      <= fd;
      end else if (out_valid_reg && out_ready) begin
        // Drained with nothing to replace it; fields keep their last values.
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Counts cycles in which a presented instruction is blocked by a hazard.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_reg <= '0;
    end else if (inst_valid && hazard && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_reg;
  assign alu_sig   = alu_sig_reg;
  assign oper1     = oper1_reg;
  assign oper2     = oper2_reg;
  assign dest      = dest_reg;
  assign mem_read  = mem_read_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
